// File: rtl/sump_cmd_pkg.sv
// Shared definitions for the SUMP command parser: FSM state encoding and the
// opcode values the downstream core decodes.
package sump_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  localparam logic [7:0] CMD_RESET      = 8'h00;
  localparam logic [7:0] CMD_RUN        = 8'h01;
  localparam logic [7:0] CMD_ID         = 8'h02;
  localparam logic [7:0] CMD_META       = 8'h04;
  localparam logic [7:0] CMD_DIV        = 8'h80;
  localparam logic [7:0] CMD_CNT        = 8'h81;
  localparam logic [7:0] CMD_FLAGS      = 8'h82;
  localparam logic [7:0] CMD_TRIG_MASK0 = 8'hC0;
  localparam logic [7:0] CMD_TRIG_VAL0  = 8'hC1;
  localparam logic [7:0] CMD_TRIG_CFG0  = 8'hC2;

endpackage

// File: rtl/sump_cmd_timeout.sv
// Idle-cycle counter for the payload phase of the command parser.
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-low
//   i_clr     clear the count (a byte was accepted)
//   i_en      counting enabled (parser is collecting payload)
//   o_expired count has reached TIMEOUT_CYC while enabled
// TIMEOUT_CYC == 0 removes the counter entirely; o_expired is then constant 0.
module sump_cmd_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic w_unused;
      assign w_unused  = ^{clk, rst, i_clr, i_en};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

      logic [CW-1:0] r_cnt;

      // Count holds at LIMIT so expiry stays asserted until the FSM leaves.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_expired = i_en && (r_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/sump_cmd_parser.sv
// SUMP byte-stream command parser. Assembles short (opcode only) and long
// (opcode + PAYLOAD_BYTES little-endian bytes) commands into one command word
// offered on a valid/ready handshake. Partial long commands are discarded after
// TIMEOUT_CYC idle cycles and counted in a saturating error counter.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   rx_data/rx_valid     incoming byte stream
//   rx_ready             parser can take a byte (0 only while holding a command)
//   cmd_valid/cmd_ready  command handshake
//   cmd_opcode           opcode byte
//   cmd_long             1 = long command, cmd_data carries the payload
//   cmd_data             payload, first byte in [7:0]; zero for short commands
//   err_cnt              timed-out partial commands, saturates at 255
module sump_cmd_parser
  import sump_cmd_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] LONG_MASK     = 8'h80,
  parameter int         TIMEOUT_CYC   = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [7:0]                 cmd_opcode,
  output logic                       cmd_long,
  output logic [8*PAYLOAD_BYTES-1:0] cmd_data,
  output logic [7:0]                 err_cnt
);

  localparam int DW = 8 * PAYLOAD_BYTES;
  localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_opcode, w_opcode_nxt;
  logic            r_long, w_long_nxt;
  logic [DW-1:0]   r_data, w_data_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [7:0]      r_err, w_err_nxt;
  logic            w_accept;
  logic            w_expired;

  // rx_ready is a pure state decode, so accept needs no extra gating.
  assign rx_ready  = (r_state != S_HOLD);
  assign cmd_valid = (r_state == S_HOLD);
  assign w_accept  = rx_valid && rx_ready;

  sump_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept),
    .i_en      (r_state == S_PAYLOAD),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
      r_long   <= 1'b0;
      r_data   <= '0;
      r_idx    <= '0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_opcode <= w_opcode_nxt;
      r_long   <= w_long_nxt;
      r_data   <= w_data_nxt;
      r_idx    <= w_idx_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_opcode_nxt = r_opcode;
    w_long_nxt   = r_long;
    w_data_nxt   = r_data;
    w_idx_nxt    = r_idx;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_opcode_nxt = rx_data;
          w_data_nxt   = '0;
          w_long_nxt   = 1'b0;
          w_idx_nxt    = '0;
          if ((rx_data & LONG_MASK) != 8'h00) begin
            w_state_nxt = S_PAYLOAD;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_PAYLOAD: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (w_accept) begin
          w_data_nxt[8*r_idx +: 8] = rx_data;
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            w_long_nxt  = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = S_HOLD;
          end
        end else if (w_expired) begin
          w_data_nxt  = '0;
          w_idx_nxt   = '0;
          w_err_nxt   = sat_inc8(r_err);
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cmd_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_opcode = r_opcode;
  assign cmd_long   = r_long;
  assign cmd_data   = r_data;
  assign err_cnt    = r_err;

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Directed bench: instance A (4-byte payload, short timeout) and instance B
// (2-byte payload, timeout disabled) share the byte stream; sel picks which
// instance's rx_ready the send task follows.
module tb_sump_cmd_parser;

  localparam int TO_A = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_ready;
  logic        sel;

  logic        a_rx_ready, a_cmd_valid, a_cmd_long;
  logic [7:0]  a_cmd_opcode, a_err_cnt;
  logic [31:0] a_cmd_data;
  logic        b_rx_ready, b_cmd_valid, b_cmd_long;
  logic [7:0]  b_cmd_opcode, b_err_cnt;
  logic [15:0] b_cmd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sump_cmd_parser #(.PAYLOAD_BYTES(4), .LONG_MASK(8'h80), .TIMEOUT_CYC(TO_A)) u_dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(a_rx_ready), .cmd_valid(a_cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(a_cmd_opcode), .cmd_long(a_cmd_long), .cmd_data(a_cmd_data),
    .err_cnt(a_err_cnt)
  );

  sump_cmd_parser #(.PAYLOAD_BYTES(2), .LONG_MASK(8'h80), .TIMEOUT_CYC(0)) u_dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(b_rx_ready), .cmd_valid(b_cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(b_cmd_opcode), .cmd_long(b_cmd_long), .cmd_data(b_cmd_data),
    .err_cnt(b_err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    logic rdy;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    rdy = sel ? b_rx_ready : a_rx_ready;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = sel ? b_rx_ready : a_rx_ready;
    end
    if (!rdy) chk("rx_ready_wait", 64'(rdy), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic stable;
    logic seen;
    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 64'(a_rx_ready), 64'd1);
    chk("rst_valid",    64'(a_cmd_valid), 64'd0);
    chk("rst_opcode",   64'(a_cmd_opcode), 64'h00);
    chk("rst_long",     64'(a_cmd_long), 64'd0);
    chk("rst_data",     64'(a_cmd_data), 64'h0);
    chk("rst_err",      64'(a_err_cnt), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Short command 0x02, consumed immediately.
    cmd_ready = 1'b1;
    send(8'h02);
    chk("short_valid",  64'(a_cmd_valid), 64'd1);
    chk("short_opcode", 64'(a_cmd_opcode), 64'h02);
    chk("short_long",   64'(a_cmd_long), 64'd0);
    chk("short_data",   64'(a_cmd_data), 64'h0);
    @(negedge clk);
    chk("short_one_cycle", 64'(a_cmd_valid), 64'd0);

    // Long command 0x81 with payload 00040004.
    cmd_ready = 1'b0;
    send(8'h81);
    chk("long_mid_valid", 64'(a_cmd_valid), 64'd0);
    send(8'h04); send(8'h00); send(8'h04); send(8'h00);
    chk("long1_valid",  64'(a_cmd_valid), 64'd1);
    chk("long1_opcode", 64'(a_cmd_opcode), 64'h81);
    chk("long1_long",   64'(a_cmd_long), 64'd1);
    chk("long1_data",   64'(a_cmd_data), 64'h00040004);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("long1_taken", 64'(a_cmd_valid), 64'd0);
    cmd_ready = 1'b0;
    send(8'h82); send(8'h38); send(8'h08); send(8'h00); send(8'h00);
    chk("long2_opcode", 64'(a_cmd_opcode), 64'h82);
    chk("long2_data",   64'(a_cmd_data), 64'h00000838);

    // Backpressure: a different command is held while another byte waits.
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    send(8'h01);
    rx_data = 8'h04; rx_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_rx_ready !== 1'b0 || a_cmd_valid !== 1'b1 || a_cmd_opcode !== 8'h01 ||
          a_cmd_long !== 1'b0 || a_cmd_data !== 32'h0)
        stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(a_rx_ready), 64'd1);
    chk("bp_release_valid", 64'(a_cmd_valid), 64'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("bp_pending_valid",  64'(a_cmd_valid), 64'd1);
    chk("bp_pending_opcode", 64'(a_cmd_opcode), 64'h04);
    @(negedge clk);

    // Timeout after TO_A+2 idle cycles mid-payload.
    send(8'hC0); send(8'hFF);
    seen = 1'b0;
    repeat (TO_A + 2) begin
      @(negedge clk);
      if (a_cmd_valid) seen = 1'b1;
    end
    chk("to_no_valid", 64'(seen), 64'd0);
    chk("to_err",      64'(a_err_cnt), 64'd1);
    chk("to_ready",    64'(a_rx_ready), 64'd1);
    send(8'h01);
    chk("to_next_valid",  64'(a_cmd_valid), 64'd1);
    chk("to_next_opcode", 64'(a_cmd_opcode), 64'h01);
    chk("to_next_long",   64'(a_cmd_long), 64'd0);
    @(negedge clk);

    // A byte on the expiry cycle wins over the timeout.
    send(8'hC1);
    repeat (TO_A) @(negedge clk);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("edge_err",   64'(a_err_cnt), 64'd1);
    chk("edge_long",  64'(a_cmd_long), 64'd1);
    chk("edge_data",  64'(a_cmd_data), 64'hDDCCBBAA);
    @(negedge clk);

    // One idle cycle more than the boundary case: the timeout must fire.
    send(8'hC1);
    repeat (TO_A + 1) @(negedge clk);
    chk("edge_plus1_err", 64'(a_err_cnt), 64'd2);

    // Drive err_cnt into saturation.
    for (int k = 0; k < 256; k++) begin
      send(8'hC0);
      repeat (TO_A + 2) @(negedge clk);
    end
    chk("err_saturate", 64'(a_err_cnt), 64'd255);

    // Reset mid-payload.
    send(8'hC2); send(8'h00); send(8'h00);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_valid",  64'(a_cmd_valid), 64'd0);
    chk("mrst_opcode", 64'(a_cmd_opcode), 64'h00);
    chk("mrst_long",   64'(a_cmd_long), 64'd0);
    chk("mrst_data",   64'(a_cmd_data), 64'h0);
    chk("mrst_err",    64'(a_err_cnt), 64'd0);
    chk("mrst_ready",  64'(a_rx_ready), 64'd1);
    send(8'h01);
    chk("mrst_next_valid",  64'(a_cmd_valid), 64'd1);
    chk("mrst_next_opcode", 64'(a_cmd_opcode), 64'h01);
    chk("mrst_next_err",    64'(a_err_cnt), 64'd0);
    @(negedge clk);

    // Instance B: 2-byte payload, no timeout.
    sel = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cmd_ready = 1'b0;
    send(8'h80); send(8'h34);
    repeat (10000) @(negedge clk);
    chk("b_gap_valid", 64'(b_cmd_valid), 64'd0);
    chk("b_gap_err",   64'(b_err_cnt), 64'd0);
    send(8'h12);
    chk("b_valid",  64'(b_cmd_valid), 64'd1);
    chk("b_opcode", 64'(b_cmd_opcode), 64'h80);
    chk("b_long",   64'(b_cmd_long), 64'd1);
    chk("b_data",   64'(b_cmd_data), 64'h1234);
    chk("b_err",    64'(b_err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
